// File: rtl/elev_pkg.sv
// elev_pkg: state and direction encodings plus default parameter values
// for the elevator floor scheduler.
// Optional feature macro: ELEV_EMERGENCY_EN (adds the EMERG state).
package elev_pkg;

`ifdef ELEV_EMERGENCY_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_DOOR  = 2'd2,
    ST_EMERG = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_t;
`endif

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  localparam int DEF_NUM_FLOORS    = 4;
  localparam int DEF_TRAVEL_CYCLES = 4;
  localparam int DEF_DOOR_CYCLES   = 3;

endpackage

// File: rtl/elev_cycle_timer.sv
// elev_cycle_timer: loadable down-counter. done is high while enabled and
// the count sits at zero; the owner reloads on done to start the next interval.
module elev_cycle_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = enable && (count == '0);

endmodule

// File: rtl/elevator_floor_scheduler.sv
// elevator_floor_scheduler: latches multi-hot floor requests and serves
// them in SCAN order, one floor per travel interval, with a door dwell at
// each stop. Optional feature macro: ELEV_EMERGENCY_EN (emergency input,
// return to floor 0 and hold the door open).
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | parked, door closed, nothing pending
//   ST_MOVE  | travelling one floor per TRAVEL_CYCLES in dir
//   ST_DOOR  | stopped with door open for DOOR_CYCLES (reloadable)
//   ST_EMERG | emergency descent to floor 0 without stopping
module elevator_floor_scheduler
  import elev_pkg::*;
#(
  parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
  parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
  parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef ELEV_EMERGENCY_EN
  input  logic                  emergency,
`endif
  input  logic [NUM_FLOORS-1:0] requested_floor,
  output logic [NUM_FLOORS-1:0] required_floor,
  output logic [NUM_FLOORS-1:0] current_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open
);

  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [NUM_FLOORS-1:0] FLOOR0      = NUM_FLOORS'(1);
  localparam logic [TW-1:0]         TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0]         DOOR_LOAD   = DW'(DOOR_CYCLES - 1);

  state_t                  state;
  dir_t                    dir;
  dir_t                    start_dir;
  dir_t                    step_dir;
  logic [NUM_FLOORS-1:0]   above_mask;
  logic [NUM_FLOORS-1:0]   below_mask;
  logic [NUM_FLOORS-1:0]   pend_up;
  logic [NUM_FLOORS-1:0]   pend_dn;
  logic [NUM_FLOORS-1:0]   latch_mask;
  logic [NUM_FLOORS-1:0]   req_eff;
  logic [NUM_FLOORS-1:0]   pending_lat;
  logic [NUM_FLOORS-1:0]   step_floor;
  logic                    at_top;
  logic                    at_bottom;
  logic                    cur_req;
  logic                    arrive_hit;
  logic                    in_motion;
  logic                    emerg_on;
  logic                    emerg_view;
  logic                    door_reload;
  logic                    travel_load;
  logic                    door_load;
  logic                    travel_done;
  logic                    door_done;

  function automatic logic [NUM_FLOORS-1:0] lowest_set(input logic [NUM_FLOORS-1:0] v);
    logic [NUM_FLOORS-1:0] r;
    r = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] highest_set(input logic [NUM_FLOORS-1:0] v);
    logic [NUM_FLOORS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

`ifdef ELEV_EMERGENCY_EN
  assign emerg_on   = emergency;
  assign in_motion  = (state == ST_MOVE) || (state == ST_EMERG);
  assign emerg_view = emergency || (state == ST_EMERG);
`else
  assign emerg_on   = 1'b0;
  assign in_motion  = (state == ST_MOVE);
  assign emerg_view = 1'b0;
`endif

  assign at_top    = current_floor[NUM_FLOORS-1];
  assign at_bottom = current_floor[0];

  // Floors strictly above / below the car.
  always_comb begin
    logic seen;
    seen       = 1'b0;
    above_mask = '0;
    below_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (current_floor[i]) begin
        seen = 1'b1;
      end else begin
        above_mask[i] = seen;
        below_mask[i] = !seen;
      end
    end
  end

  assign pend_up = pending & above_mask;
  assign pend_dn = pending & below_mask;

  // During travel the car has left its floor, so a request there is a real new stop.
  assign latch_mask  = (state == ST_MOVE) ? '1 : ~current_floor;
  assign req_eff     = emerg_on ? '0 : requested_floor;
  assign pending_lat = emerg_on ? '0 : (pending | (req_eff & latch_mask));
  assign cur_req     = |(req_eff & current_floor);

  assign step_floor = (dir == UP) ? (at_top ? current_floor : (current_floor << 1))
                                  : (at_bottom ? current_floor : (current_floor >> 1));
  assign arrive_hit = |(pending_lat & step_floor);

  // Direction to leave with: keep going if work remains ahead, else reverse; walls win.
  always_comb begin
    if (dir == UP) start_dir = (|pend_up) ? UP : DOWN;
    else           start_dir = (|pend_dn) ? DOWN : UP;
    if (at_top)    start_dir = DOWN;
    if (at_bottom) start_dir = UP;
  end

  // Direction after a step, forced by the end floors.
  always_comb begin
    step_dir = dir;
    if (step_floor[NUM_FLOORS-1]) step_dir = DOWN;
    else if (step_floor[0])       step_dir = UP;
  end

  // Next-stop target: nearest pending ahead, else nearest behind, else here.
  always_comb begin
    if (emerg_view) begin
      required_floor = FLOOR0;
    end else if (dir == UP) begin
      required_floor = (|pend_up) ? lowest_set(pend_up)
                     : (|pend_dn) ? highest_set(pend_dn) : current_floor;
    end else begin
      required_floor = (|pend_dn) ? highest_set(pend_dn)
                     : (|pend_up) ? lowest_set(pend_up) : current_floor;
    end
  end

  // Timers sit preloaded outside their state so the first interval is full length.
  assign door_reload = cur_req || (emerg_on && at_bottom);
  assign travel_load = !in_motion || travel_done;
  assign door_load   = (state != ST_DOOR) || door_reload;

  elev_cycle_timer #(.WIDTH(TW)) u_travel_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (travel_load),
    .load_value (TRAVEL_LOAD),
    .enable     (in_motion),
    .done       (travel_done)
  );

  elev_cycle_timer #(.WIDTH(DW)) u_door_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (door_load),
    .load_value (DOOR_LOAD),
    .enable     (state == ST_DOOR),
    .done       (door_done)
  );

  // Scheduler FSM with registered position, request latch and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      dir           <= UP;
      current_floor <= FLOOR0;
      pending       <= '0;
      moving_up     <= 1'b0;
      moving_down   <= 1'b0;
      door_open     <= 1'b0;
    end else begin
      pending <= pending_lat;
      case (state)
        ST_IDLE: begin
`ifdef ELEV_EMERGENCY_EN
          if (emerg_on && !at_bottom) begin
            state       <= ST_EMERG;
            dir         <= DOWN;
            moving_down <= 1'b1;
          end else
`endif
          if (cur_req || (emerg_on && at_bottom)) begin
            state     <= ST_DOOR;
            door_open <= 1'b1;
          end else if (|pending) begin
            state       <= ST_MOVE;
            dir         <= start_dir;
            moving_up   <= (start_dir == UP);
            moving_down <= (start_dir == DOWN);
          end
        end

        ST_MOVE: begin
          if (travel_done) begin
            current_floor <= step_floor;
            dir           <= step_dir;
`ifdef ELEV_EMERGENCY_EN
            if (emerg_on) begin
              moving_up <= 1'b0;
              if (step_floor[0]) begin
                state       <= ST_DOOR;
                door_open   <= 1'b1;
                moving_down <= 1'b0;
              end else begin
                state       <= ST_EMERG;
                dir         <= DOWN;
                moving_down <= 1'b1;
              end
            end else
`endif
            if (arrive_hit) begin
              pending     <= pending_lat & ~step_floor;
              state       <= ST_DOOR;
              door_open   <= 1'b1;
              moving_up   <= 1'b0;
              moving_down <= 1'b0;
            end else begin
              moving_up   <= (step_dir == UP);
              moving_down <= (step_dir == DOWN);
            end
          end
        end

        ST_DOOR: begin
`ifdef ELEV_EMERGENCY_EN
          if (emerg_on && !at_bottom) begin
            state       <= ST_EMERG;
            dir         <= DOWN;
            door_open   <= 1'b0;
            moving_down <= 1'b1;
          end else
`endif
          if (door_done && !door_reload) begin
            door_open <= 1'b0;
            if (|pending) begin
              state       <= ST_MOVE;
              dir         <= start_dir;
              moving_up   <= (start_dir == UP);
              moving_down <= (start_dir == DOWN);
            end else begin
              state <= ST_IDLE;
            end
          end
        end

`ifdef ELEV_EMERGENCY_EN
        ST_EMERG: begin
          if (travel_done) begin
            current_floor <= step_floor;
            if (step_floor[0]) begin
              state       <= ST_DOOR;
              dir         <= UP;
              door_open   <= 1'b1;
              moving_down <= 1'b0;
            end
          end
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_floor_scheduler.sv
// tb_elevator_floor_scheduler: scenario tasks with a stop scoreboard.
// Expected door stops (floor, opening cycle, dwell length) are queued when
// stimulus is applied; a monitor records the actual stops as they happen.
module tb_elevator_floor_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] requested_floor = '0;
  logic [3:0] required_floor;
  logic [3:0] current_floor;
  logic [3:0] pending;
  logic       moving_up;
  logic       moving_down;
  logic       door_open;
`ifdef ELEV_EMERGENCY_EN
  logic       emergency = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0] floor;
    int         start;
    int         len;
  } stop_t;

  stop_t exp_q[$];
  stop_t act_q[$];
  stop_t cur_ev;
  logic  in_door = 1'b0;

  elevator_floor_scheduler dut (
    .clk             (clk),
    .rst             (rst),
`ifdef ELEV_EMERGENCY_EN
    .emergency       (emergency),
`endif
    .requested_floor (requested_floor),
    .required_floor  (required_floor),
    .current_floor   (current_floor),
    .pending         (pending),
    .moving_up       (moving_up),
    .moving_down     (moving_down),
    .door_open       (door_open)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stop monitor: records each door-open interval.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      in_door = 1'b0;
    end else if (door_open && !in_door) begin
      in_door      = 1'b1;
      cur_ev.floor = current_floor;
      cur_ev.start = cyc;
      cur_ev.len   = 1;
    end else if (door_open) begin
      cur_ev.len++;
    end else if (in_door) begin
      in_door = 1'b0;
      act_q.push_back(cur_ev);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  function automatic stop_t make_stop(input logic [3:0] f, input int s, input int l);
    stop_t r;
    r.floor = f;
    r.start = s;
    r.len   = l;
    return r;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    requested_floor = '0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    checks++; if (current_floor !== 4'b0001) begin errors++; $display("FAIL reset_current: got %b want 0001", current_floor); end
    checks++; if (required_floor !== 4'b0001) begin errors++; $display("FAIL reset_required: got %b want 0001", required_floor); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b want 0000", pending); end
    checks++; if (moving_up !== 1'b0) begin errors++; $display("FAIL reset_moving_up: got %b want 0", moving_up); end
    checks++; if (moving_down !== 1'b0) begin errors++; $display("FAIL reset_moving_down: got %b want 0", moving_down); end
    checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL reset_door: got %b want 0", door_open); end
    rst = 1'b0;
  endtask

  task automatic test_single_request();
    int n;
    stop_t e, a;
    do_reset();
    requested_floor = 4'b0100;
    step(1);
    n = cyc;
    requested_floor = '0;
    exp_q.push_back(make_stop(4'b0100, n + 9, 3));
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL single_pending: got %b want 0100", pending); end
    checks++; if (required_floor !== 4'b0100) begin errors++; $display("FAIL single_required: got %b want 0100", required_floor); end
    step(1);
    checks++; if (moving_up !== 1'b1) begin errors++; $display("FAIL single_moving_up: got %b want 1", moving_up); end
    step(3);
    checks++; if (current_floor !== 4'b0001) begin errors++; $display("FAIL single_before_step: got %b want 0001", current_floor); end
    step(1);
    checks++; if (current_floor !== 4'b0010) begin errors++; $display("FAIL single_floor1: got %b want 0010", current_floor); end
    step(4);
    checks++; if (current_floor !== 4'b0100) begin errors++; $display("FAIL single_floor2: got %b want 0100", current_floor); end
    checks++; if (moving_up !== 1'b0) begin errors++; $display("FAIL single_stop_flag: got %b want 0", moving_up); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL single_cleared: got %b want 0000", pending); end
    for (int i = 0; i < 50 && act_q.size() < 1; i++) step(1);
    checks++;
    if (act_q.size() < 1) begin errors++; $display("FAIL single_stops: got %0d stops want 1", act_q.size()); end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++; if (a.floor !== e.floor) begin errors++; $display("FAIL single_stop_floor: got %b want %b", a.floor, e.floor); end
      checks++; if (a.start !== e.start) begin errors++; $display("FAIL single_stop_cycle: got %0d want %0d", a.start, e.start); end
      checks++; if (a.len !== e.len) begin errors++; $display("FAIL single_dwell: got %0d want %0d", a.len, e.len); end
    end
    step(1);
    checks++; if (required_floor !== 4'b0100) begin errors++; $display("FAIL single_idle_required: got %b want 0100", required_floor); end
    checks++; if (moving_up !== 1'b0 || moving_down !== 1'b0) begin errors++; $display("FAIL single_idle_flags: got %b%b want 00", moving_up, moving_down); end
  endtask

  task automatic test_two_requests();
    int n;
    stop_t e, a;
    do_reset();
    requested_floor = 4'b1010;
    step(1);
    n = cyc;
    requested_floor = '0;
    exp_q.push_back(make_stop(4'b0010, n + 5, 3));
    exp_q.push_back(make_stop(4'b1000, n + 16, 3));
    checks++; if (required_floor !== 4'b0010) begin errors++; $display("FAIL two_required_first: got %b want 0010", required_floor); end
    step(5);
    checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL two_door_first: got %b want 1", door_open); end
    checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL two_pending_after_first: got %b want 1000", pending); end
    checks++; if (required_floor !== 4'b1000) begin errors++; $display("FAIL two_required_second: got %b want 1000", required_floor); end
    step(3);
    checks++; if (moving_up !== 1'b1 || door_open !== 1'b0) begin errors++; $display("FAIL two_resume: got up=%b door=%b want up=1 door=0", moving_up, door_open); end
    for (int i = 0; i < 80 && act_q.size() < 2; i++) step(1);
    checks++;
    if (act_q.size() < 2) begin errors++; $display("FAIL two_stops: got %0d stops want 2", act_q.size()); end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++; if (a.floor !== e.floor) begin errors++; $display("FAIL two_stop_floor: got %b want %b", a.floor, e.floor); end
      checks++; if (a.start !== e.start) begin errors++; $display("FAIL two_stop_cycle: got %0d want %0d", a.start, e.start); end
      checks++; if (a.len !== e.len) begin errors++; $display("FAIL two_dwell: got %0d want %0d", a.len, e.len); end
    end
    checks++; if (current_floor !== 4'b1000) begin errors++; $display("FAIL two_final_floor: got %b want 1000", current_floor); end
  endtask

  task automatic test_reversal();
    int n;
    stop_t e, a;
    do_reset();
    requested_floor = 4'b1000;
    step(1);
    n = cyc;
    requested_floor = '0;
    step(9);
    checks++; if (current_floor !== 4'b0100 || moving_up !== 1'b1) begin errors++; $display("FAIL rev_setup: got floor=%b up=%b want 0100 1", current_floor, moving_up); end
    requested_floor = 4'b0001;
    step(1);
    requested_floor = '0;
    exp_q.push_back(make_stop(4'b1000, n + 13, 3));
    exp_q.push_back(make_stop(4'b0001, n + 28, 3));
    checks++; if (pending !== 4'b1001) begin errors++; $display("FAIL rev_pending: got %b want 1001", pending); end
    checks++; if (required_floor !== 4'b1000) begin errors++; $display("FAIL rev_required_up: got %b want 1000", required_floor); end
    step(7);
    checks++; if (moving_down !== 1'b1 || moving_up !== 1'b0) begin errors++; $display("FAIL rev_moving_down: got down=%b up=%b want 1 0", moving_down, moving_up); end
    checks++; if (required_floor !== 4'b0001) begin errors++; $display("FAIL rev_required_down: got %b want 0001", required_floor); end
    for (int i = 0; i < 80 && act_q.size() < 2; i++) step(1);
    checks++;
    if (act_q.size() < 2) begin errors++; $display("FAIL rev_stops: got %0d stops want 2", act_q.size()); end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++; if (a.floor !== e.floor) begin errors++; $display("FAIL rev_stop_floor: got %b want %b", a.floor, e.floor); end
      checks++; if (a.start !== e.start) begin errors++; $display("FAIL rev_stop_cycle: got %0d want %0d", a.start, e.start); end
      checks++; if (a.len !== e.len) begin errors++; $display("FAIL rev_dwell: got %0d want %0d", a.len, e.len); end
    end
    checks++; if (current_floor !== 4'b0001 || moving_down !== 1'b0) begin errors++; $display("FAIL rev_final: got floor=%b down=%b want 0001 0", current_floor, moving_down); end
  endtask

  task automatic test_current_floor_request();
    int n;
    stop_t e, a;
    do_reset();
    requested_floor = 4'b0001;
    step(1);
    n = cyc;
    requested_floor = '0;
    exp_q.push_back(make_stop(4'b0001, n, 3));
    checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL cur_door: got %b want 1", door_open); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL cur_pending: got %b want 0000", pending); end
    checks++; if (moving_up !== 1'b0 || moving_down !== 1'b0) begin errors++; $display("FAIL cur_flags: got %b%b want 00", moving_up, moving_down); end
    for (int i = 0; i < 30 && act_q.size() < 1; i++) step(1);
    checks++;
    if (act_q.size() < 1) begin errors++; $display("FAIL cur_stops: got %0d stops want 1", act_q.size()); end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      checks++; if (a.floor !== e.floor) begin errors++; $display("FAIL cur_stop_floor: got %b want %b", a.floor, e.floor); end
      checks++; if (a.start !== e.start) begin errors++; $display("FAIL cur_stop_cycle: got %0d want %0d", a.start, e.start); end
      checks++; if (a.len !== e.len) begin errors++; $display("FAIL cur_dwell: got %0d want %0d", a.len, e.len); end
    end
    checks++; if (current_floor !== 4'b0001 || pending !== 4'b0000) begin errors++; $display("FAIL cur_final: got floor=%b pending=%b want 0001 0000", current_floor, pending); end
  endtask

  task automatic test_reset_mid_move();
    do_reset();
    requested_floor = 4'b0100;
    step(1);
    requested_floor = '0;
    step(6);
    checks++; if (current_floor !== 4'b0010 || moving_up !== 1'b1) begin errors++; $display("FAIL midrst_setup: got floor=%b up=%b want 0010 1", current_floor, moving_up); end
    #1 rst = 1'b1;
    #1;
    checks++; if (current_floor !== 4'b0001) begin errors++; $display("FAIL midrst_current: got %b want 0001", current_floor); end
    checks++; if (required_floor !== 4'b0001) begin errors++; $display("FAIL midrst_required: got %b want 0001", required_floor); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL midrst_pending: got %b want 0000", pending); end
    checks++; if (moving_up !== 1'b0 || door_open !== 1'b0) begin errors++; $display("FAIL midrst_flags: got up=%b door=%b want 0 0", moving_up, door_open); end
    step(1);
    rst = 1'b0;
    step(12);
    checks++; if (current_floor !== 4'b0001 || moving_up !== 1'b0) begin errors++; $display("FAIL midrst_after: got floor=%b up=%b want 0001 0", current_floor, moving_up); end
    checks++; if (act_q.size() != 0) begin errors++; $display("FAIL midrst_no_stop: got %0d stops want 0", act_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_two_requests();
    test_reversal();
    test_current_floor_request();
    test_reset_mid_move();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
